mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Sequential MIPS MULT/DIV engine; operates beside the ALU/shifter stage on the same A/B operands.
- Produces the 64-bit {HI,LO} result that the downstream HI/LO registers capture for MFHI/MFLO.
- The control unit starts an operation and waits on done/busy, like the other multicycle datapath ops.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits. Only 32 is verified.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- MDSrcA  input  WIDTH  multiplicand / dividend
- MDSrcB  input  WIDTH  multiplier / divisor
- MDOp  input  1  0 = MULT, 1 = DIV; sampled with start
- start  input  1  request; accepted only in IDLE
- busy  output  1  high from the cycle after acceptance until done
- done  output  1  one-cycle pulse; HI/LO valid from this cycle on
- DIV_ZERO  output  1  one-cycle pulse together with done when a DIV divisor is 0
- HI  output  WIDTH  MULT: product[63:32]; DIV: remainder
- LO  output  WIDTH  MULT: product[31:0]; DIV: quotient

Behaviour:
- Reset (async, active-high): state = IDLE; HI, LO, busy, done, DIV_ZERO, counter and internal registers all 0. Reset mid-operation aborts the operation and produces no done.
- States: IDLE, MULT, DIV, FINISH.
- IDLE:
  - On start = 1, latch MDSrcA, MDSrcB and MDOp; clear the counter.
  - MDOp = 0: go to MULT.
  - MDOp = 1 with MDSrcB != 0: go to DIV.
  - MDOp = 1 with MDSrcB == 0: go to FINISH with a div-by-zero flag set.
- MULT: radix-2 Booth, one iteration per cycle, 32 cycles; arithmetic shift right of {Acc,Q,q-1}. Then go to FINISH.
- DIV: restoring division on |A| and |B|, one quotient bit per cycle, 32 cycles. Then go to FINISH.
- FINISH (one cycle):
  - Write HI/LO.
  - DIV sign fix: quotient negated if sign(A) != sign(B); remainder takes the sign of A. Results truncate toward zero, per MIPS.
  - done = 1 for this cycle; DIV_ZERO = 1 if the flag is set. Next state is IDLE.
- Divide-by-zero: HI and LO are NOT updated; they keep their prior values.
- Special case 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. No trap.
- Latency: start accepted at edge 0 → done high in the cycle after edge 33 (MULT/DIV). Divide-by-zero: done in the cycle after edge 1.
- busy = 1 in MULT and DIV, and in FINISH; 0 in IDLE.
- start while busy is ignored; operands are not re-latched.
- Operand inputs may change freely after acceptance.
- HI/LO hold their last value indefinitely between operations.
- Back-to-back operation: start may be asserted in the cycle done is high. It is sampled at the next edge (state is then IDLE) and accepted, giving zero dead cycles.

Optional Feature:
- Macro MULTDIV_UNSIGNED_EN.
- Defined:
  - Adds input port MDUnsigned (1 bit), sampled with start.
  - When 1: MULTU/DIVU semantics. Operands are zero-extended, MULT uses a 33-bit Booth accumulator, DIV skips sign handling and the sign fix.
  - Latency unchanged.
- Undefined: the port is absent and all operations are signed.

Test Plan:
- MULT A = 7, B = 0xFFFFFFFD (-3) → done 33 cycles after start; HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; busy high for the 33 preceding cycles.
- MULT A = 0x80000000, B = 0x80000000 → HI = 0x40000000, LO = 0x00000000.
- DIV A = 0xFFFFFFF9 (-7), B = 2 → LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1). Then DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- Preload HI = 0x11, LO = 0x22 via MULT 0x11 × ... (any known result); then DIV 5 / 0 → done and DIV_ZERO both pulse in the cycle after edge 1; HI/LO unchanged.
- Start MULT 3 × 4 and pulse start again with DIV at cycle 5 → second start ignored; result HI = 0, LO = 12. Then assert start in the done cycle with DIV 100 / 7 → accepted immediately; LO = 14, HI = 2.
- Start DIV, assert reset at cycle 10 → all outputs 0 immediately, no done pulse. Release reset, then MULT 6 × 7 → LO = 42 after 33 cycles.

Source files
------------

// File: rtl/mult_div_unit.sv
// Sequential MIPS MULT/DIV engine: radix-2 Booth multiply and restoring divide, 32 iterations each.
// Optional MULTDIV_UNSIGNED_EN adds the MDUnsigned port for MULTU/DIVU semantics.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] MDSrcA,
  input  logic [WIDTH-1:0] MDSrcB,
  input  logic             MDOp,
  input  logic             start,
`ifdef MULTDIV_UNSIGNED_EN
  input  logic             MDUnsigned,
`endif
  output logic             busy,
  output logic             done,
  output logic             DIV_ZERO,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  // Two guard bits keep the Booth accumulator and the divide trial subtraction from overflowing.
  localparam int unsigned ACC_W = WIDTH + 2;

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_FINISH} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic               qm1_q, qm1_d;
  logic               op_q, op_d;
  logic               uns_q, uns_d;
  logic               bmsb_q, bmsb_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dzo_q, dzo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               uns_in;
  logic [ACC_W-1:0]   sum;
  logic [ACC_W-1:0]   trial;
  logic [WIDTH:0]     shifted;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;

`ifdef MULTDIV_UNSIGNED_EN
  assign uns_in = MDUnsigned;
`else
  assign uns_in = 1'b0;
`endif

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    m_d       = m_q;
    mq_d      = mq_q;
    qm1_d     = qm1_q;
    op_d      = op_q;
    uns_d     = uns_q;
    bmsb_d    = bmsb_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dzo_d     = 1'b0;
    sum       = acc_q;
    trial     = '0;
    shifted   = '0;

    a_neg = ~uns_in & MDSrcA[WIDTH-1];
    b_neg = ~uns_in & MDSrcB[WIDTH-1];
    a_abs = a_neg ? -MDSrcA : MDSrcA;
    b_abs = b_neg ? -MDSrcB : MDSrcB;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = MDOp;
          uns_d = uns_in;
          cnt_d = '0;
          acc_d = '0;
          qm1_d = 1'b0;
          dz_d  = 1'b0;
          if (!MDOp) begin
            m_d     = uns_in ? {2'b00, MDSrcA} : {{2{MDSrcA[WIDTH-1]}}, MDSrcA};
            mq_d    = MDSrcB;
            bmsb_d  = MDSrcB[WIDTH-1];
            state_d = S_MULT;
          end else begin
            m_d       = {2'b00, b_abs};
            mq_d      = a_abs;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            if (MDSrcB == '0) begin
              dz_d    = 1'b1;
              state_d = S_FINISH;
            end else begin
              state_d = S_DIV;
            end
          end
        end
      end

      S_MULT: begin
        case ({mq_q[0], qm1_q})
          2'b01:   sum = acc_q + m_q;
          2'b10:   sum = acc_q - m_q;
          default: sum = acc_q;
        endcase
        // Arithmetic shift right of {acc, Q, q-1}
        acc_d = {sum[ACC_W-1], sum[ACC_W-1:1]};
        mq_d  = {sum[0], mq_q[WIDTH-1:1]};
        qm1_d = mq_q[0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FINISH;
      end

      S_DIV: begin
        shifted = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
        trial   = {1'b0, shifted} - m_q;
        if (!trial[ACC_W-1]) begin
          acc_d = trial;
          mq_d  = {mq_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {1'b0, shifted};
          mq_d  = {mq_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FINISH;
      end

      S_FINISH: begin
        done_d  = 1'b1;
        dzo_d   = dz_q;
        state_d = S_IDLE;
        if (!dz_q) begin
          if (!op_q) begin
            // Booth treats the multiplier as signed; add M<<32 back for an unsigned multiplier with MSB set.
            hi_d = acc_q[WIDTH-1:0] + ((uns_q && bmsb_q) ? m_q[WIDTH-1:0] : '0);
            lo_d = mq_q;
          end else begin
            lo_d = neg_quo_q ? -mq_q : mq_q;
            hi_d = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      m_q       <= '0;
      mq_q      <= '0;
      qm1_q     <= 1'b0;
      op_q      <= 1'b0;
      uns_q     <= 1'b0;
      bmsb_q    <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dzo_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      mq_q      <= mq_d;
      qm1_q     <= qm1_d;
      op_q      <= op_d;
      uns_q     <= uns_d;
      bmsb_q    <= bmsb_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dzo_q     <= dzo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign DIV_ZERO = dzo_q;
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule
